// File: rtl/instr_mem_pkg.sv
// Shared types and constants for the synchronous-read instruction memory.
package instr_mem_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int FAULT_MISALIGN = 0;
  localparam int FAULT_RANGE    = 1;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
    logic [1:0]  fault;
  } fetch_rsp_t;

endpackage

// File: rtl/instr_mem_array.sv
// Plain storage: synchronous write, registered read. Drop-in point for a vendor BRAM.
module instr_mem_array #(
  parameter int DEPTH  = 256,
  parameter int DATA_W = 32,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents are deliberately not reset so a preloaded program survives rst_n.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_idx];
  end

endmodule

// File: rtl/instr_mem_sync.sv
// Fetch-side instruction memory: valid/ready request, one-cycle registered response,
// word preload port, redirect flush, fault flags and retired-fetch counter.
module instr_mem_sync
  import instr_mem_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 256,
  parameter int                IDX_W     = $clog2(DEPTH),
  parameter logic [DATA_W-1:0] NOP_INSTR = instr_mem_pkg::NOP_INSTR
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              flush,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_instr,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [1:0]        rsp_fault,
  input  logic              ld_en,
  input  logic [IDX_W-1:0]  ld_idx,
  input  logic [DATA_W-1:0] ld_data,
  output logic [31:0]       fetch_cnt
);

  logic              accept;
  logic [1:0]        req_fault;
  logic [DATA_W-1:0] rd_data;

  assign req_ready = rst_n & ~ld_en & ~flush & (~rsp_valid | rsp_ready);
  assign accept    = req_valid & req_ready;

  always_comb begin
    req_fault                 = 2'b00;
    req_fault[FAULT_MISALIGN] = |req_addr[1:0];
    req_fault[FAULT_RANGE]    = |req_addr[ADDR_W-1:IDX_W+2];
  end

  instr_mem_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (ld_en),
    .wr_idx  (ld_idx),
    .wr_data (ld_data),
    .rd_en   (accept),
    .rd_idx  (req_addr[IDX_W+1:2]),
    .rd_data (rd_data)
  );

  // Read register only moves on accept, so a held response stays stable under loads.
  assign rsp_instr = (|rsp_fault) ? NOP_INSTR : rd_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_addr  <= '0;
      rsp_fault <= 2'b00;
      fetch_cnt <= 32'd0;
    end else begin
      if (rsp_valid && rsp_ready) fetch_cnt <= fetch_cnt + 32'd1;
      if (accept) begin
        rsp_valid <= 1'b1;
        rsp_addr  <= req_addr;
        rsp_fault <= req_fault;
      end else if (flush || rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_mem_sync.sv
// Directed plus randomized bench for instr_mem_sync against a transaction-level model.
module tb_instr_mem_sync;
  import instr_mem_pkg::*;

  localparam int DEPTH = 256;
  localparam int IDX_W = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic [31:0]       req_addr;
  logic              flush;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_instr;
  logic [31:0]       rsp_addr;
  logic [1:0]        rsp_fault;
  logic              ld_en;
  logic [IDX_W-1:0]  ld_idx;
  logic [31:0]       ld_data;
  logic [31:0]       fetch_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] ref_mem [DEPTH];
  logic        exp_valid;
  fetch_rsp_t  exp_rsp;
  logic [31:0] exp_cnt;

  always #5 clk = ~clk;

  instr_mem_sync #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .flush     (flush),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_instr (rsp_instr),
    .rsp_addr  (rsp_addr),
    .rsp_fault (rsp_fault),
    .ld_en     (ld_en),
    .ld_idx    (ld_idx),
    .ld_data   (ld_data),
    .fetch_cnt (fetch_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic fetch_rsp_t ref_fetch(input logic [31:0] a);
    fetch_rsp_t  r;
    logic [31:0] wi;
    r.addr                 = a;
    r.fault                = 2'b00;
    r.fault[FAULT_MISALIGN] = (a % 4) != 0;
    r.fault[FAULT_RANGE]    = (a / 4) >= DEPTH;
    wi                     = (a / 4) % DEPTH;
    r.instr                = (r.fault != 2'b00) ? NOP_INSTR : ref_mem[wi[IDX_W-1:0]];
    return r;
  endfunction

  // One clock: drive after the edge, check at negedge, advance the model at posedge.
  task automatic cyc(input logic v, input logic [31:0] a, input logic rr, input logic fl,
                     input logic ld, input logic [IDX_W-1:0] li, input logic [31:0] ldd);
    logic exp_ready;
    logic acc;
    req_valid = v;  req_addr = a;  rsp_ready = rr;  flush = fl;
    ld_en = ld;     ld_idx = li;   ld_data = ldd;
    exp_ready = rst_n && !ld && !fl && (!exp_valid || rr);
    @(negedge clk);
    chk("req_ready", 64'(req_ready), 64'(exp_ready));
    chk("rsp_valid", 64'(rsp_valid), 64'(exp_valid));
    if (exp_valid) begin
      chk("rsp_instr", 64'(rsp_instr), 64'(exp_rsp.instr));
      chk("rsp_addr",  64'(rsp_addr),  64'(exp_rsp.addr));
      chk("rsp_fault", 64'(rsp_fault), 64'(exp_rsp.fault));
    end
    chk("fetch_cnt", 64'(fetch_cnt), 64'(exp_cnt));
    @(posedge clk);
    if (rst_n) begin
      acc = v && exp_ready;
      if (exp_valid && rr) exp_cnt = exp_cnt + 32'd1;
      if (acc) begin
        exp_valid = 1'b1;
        exp_rsp   = ref_fetch(a);
      end else if (fl || rr) begin
        exp_valid = 1'b0;
      end
      if (ld) ref_mem[li] = ldd;
    end
    #1;
  endtask

  task automatic idle(input logic rr);
    cyc(1'b0, 32'd0, rr, 1'b0, 1'b0, '0, 32'd0);
  endtask

  task automatic fetch(input logic [31:0] a, input logic rr);
    cyc(1'b1, a, rr, 1'b0, 1'b0, '0, 32'd0);
  endtask

  function automatic logic [31:0] rand_addr();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel < 8)       return {22'd0, 8'($urandom_range(0, DEPTH - 1)), 2'b00};
    else if (sel == 8) return 32'($urandom_range(0, 4 * DEPTH + 3));
    else               return $urandom;
  endfunction

  initial begin
    rst_n = 1'b0;  req_valid = 1'b0;  req_addr = 32'd0;  flush = 1'b0;
    rsp_ready = 1'b0;  ld_en = 1'b0;  ld_idx = '0;  ld_data = 32'd0;
    exp_valid = 1'b0;  exp_cnt = 32'd0;  exp_rsp = '0;

    #2;
    chk("rst_valid", 64'(rsp_valid), 64'd0);
    chk("rst_instr", 64'(rsp_instr), 64'd0);
    chk("rst_addr",  64'(rsp_addr),  64'd0);
    chk("rst_fault", 64'(rsp_fault), 64'd0);
    chk("rst_cnt",   64'(fetch_cnt), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    fetch(32'd0, 1'b1);
    rst_n = 1'b1;

    // Preload: words 0..8 get the pattern, the rest random.
    for (int i = 0; i < DEPTH; i++)
      cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, IDX_W'(i),
          (i <= 8) ? 32'h0000_0013 + 32'h100 * 32'(i) : $urandom);

    for (int i = 0; i <= 8; i++) fetch(32'(4 * i), 1'b1);
    idle(1'b1);
    chk("cnt_after_9", 64'(fetch_cnt), 64'd9);

    fetch(32'h6, 1'b1);
    fetch(32'(4 * DEPTH), 1'b1);
    fetch(32'(4 * DEPTH + 2), 1'b1);
    idle(1'b1);

    // Stall: response held for 5 cycles while a new request waits.
    fetch(32'd20, 1'b1);
    for (int i = 0; i < 5; i++) fetch(32'd24, 1'b0);
    fetch(32'd24, 1'b1);
    idle(1'b1);

    // Flush against a stalled response.
    fetch(32'd16, 1'b1);
    cyc(1'b1, 32'd28, 1'b0, 1'b1, 1'b0, '0, 32'd0);
    idle(1'b0);
    idle(1'b1);

    // Load blocks requests; a fetch the next cycle sees the new word.
    cyc(1'b1, 32'd12, 1'b1, 1'b0, 1'b1, IDX_W'(3), 32'hDEAD_BEEF);
    fetch(32'd12, 1'b1);
    idle(1'b1);

    // Load over the word backing a held response leaves the response alone.
    fetch(32'd8, 1'b1);
    cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, IDX_W'(2), 32'h1234_5678);
    idle(1'b0);
    idle(1'b1);

    // Asynchronous reset while a response is held.
    fetch(32'd4, 1'b1);
    idle(1'b0);
    fetch(32'd8, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(rsp_valid), 64'd0);
    chk("async_rst_cnt",   64'(fetch_cnt), 64'd0);
    chk("async_rst_ready", 64'(req_ready), 64'd0);
    exp_valid = 1'b0;
    exp_cnt   = 32'd0;
    @(posedge clk); #1;
    idle(1'b1);
    rst_n = 1'b1;
    fetch(32'd4, 1'b1);
    fetch(32'd12, 1'b1);
    idle(1'b1);

    for (int i = 0; i < 2000; i++)
      cyc($urandom_range(0, 3) != 0, rand_addr(), $urandom_range(0, 2) != 0,
          $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0,
          IDX_W'($urandom_range(0, DEPTH - 1)), $urandom);
    idle(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_mem_sync.md
# instr_mem_sync

Parametrised, synchronous-read instruction memory for the RISC-V core's fetch stage. It replaces the combinational address-to-instruction ROM with a registered read behind a valid/ready request/response handshake. It also adds a word-load port for program preloading, a redirect flush, fault flags for misaligned or out-of-range fetches, and a retired-fetch counter. It sits between the PC/fetch logic and the decode stage.

## Interface
Parameters:
- `ADDR_W`, 32, byte-address width.
- `DATA_W`, 32, instruction word width. Fixed at 32 for RV32I; other values are unsupported.
- `DEPTH`, 256, number of instruction words; power of two, ≥ 4.
- `IDX_W`, $clog2(DEPTH), word-index width; derived, not overridden.
- `NOP_INSTR`, 32'h0000_0013, instruction returned on a fault (`addi x0,x0,0`).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  fetch request present.
- `req_ready`  out  1  request accepted this cycle when high together with `req_valid`.
- `req_addr`  in  ADDR_W  byte address of the fetch.
- `flush`  in  1  redirect; kills the pending response.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer takes the response.
- `rsp_instr`  out  DATA_W  fetched instruction.
- `rsp_addr`  out  ADDR_W  byte address that produced `rsp_instr`.
- `rsp_fault`  out  2  bit0 = misaligned (`req_addr[1:0]` ≠ 0); bit1 = out of range (`req_addr[ADDR_W-1:2]` ≥ DEPTH).
- `ld_en`  in  1  write one word into the memory.
- `ld_idx`  in  IDX_W  word index to write.
- `ld_data`  in  DATA_W  word to write.
- `fetch_cnt`  out  32  count of completed responses.

## Operation
- Storage is a DEPTH×DATA_W array. It is not reset; contents are undefined until loaded.
- Load: when `ld_en` is high, `mem[ld_idx] <= ld_data` at the clock edge. Loads have priority over fetches.
- Ready rule: `req_ready = rst_n & ~ld_en & ~flush & (~rsp_valid | rsp_ready)`. This gives full throughput of one fetch per cycle while the consumer is ready.
- Accept (`req_valid & req_ready`): at the next edge the response register captures the following, and sets `rsp_valid <= 1`:
  - `rsp_addr <= req_addr`
  - `rsp_fault` computed from `req_addr`
  - `rsp_instr <=` `NOP_INSTR` if either fault bit is set, otherwise `mem[req_addr[IDX_W+1:2]]`
- Both fault bits may be set together.
- Completion (`rsp_valid & rsp_ready`) with no accept in the same cycle: `rsp_valid <= 0` and `fetch_cnt` increments.
- Stall (`rsp_valid & ~rsp_ready`): `rsp_valid`, `rsp_instr`, `rsp_addr` and `rsp_fault` hold bit-stable, and `req_ready` is 0.
- Flush: at the next edge `rsp_valid <= 0`. No request is accepted in the flush cycle. A response completed in the flush cycle (`rsp_valid & rsp_ready`) still counts in `fetch_cnt`.
- Counter: `fetch_cnt` wraps from 0xFFFF_FFFF to 0.
- `ld_en` high while a response is held: the held `rsp_instr` does not change, even if its word is overwritten.

## Timing
- Read latency is 1 cycle, from the accept edge to `rsp_valid` high with data.
- Back-to-back: one accept and one completion per cycle with no bubble.
- Reset values: `rsp_valid`=0, `rsp_instr`=0, `rsp_addr`=0, `rsp_fault`=0, `fetch_cnt`=0. `req_ready`=0 while `rst_n` is low.
- Reset asserted mid-transaction drops the pending response immediately (asynchronously). Memory contents survive reset.
- A load at word N in cycle t followed by a fetch of N accepted in cycle t+1 returns the new data.

## Structure
- Shared package `instr_mem_pkg` holds:
  - `NOP_INSTR`
  - fault-bit position constants `FAULT_MISALIGN=0` and `FAULT_RANGE=1`
  - a `fetch_rsp_t` struct of instr/addr/fault
- One natural sub-module: `instr_mem_array`, the plain synchronous-write, registered-read storage. Keep it separate so it can be swapped for a vendor BRAM.

## Test plan
- Load words 0..8 with 0x0000_0013 + 0x100·i, then fetch byte addresses 0, 4, …, 32 back-to-back with `rsp_ready`=1. Required: 9 responses on consecutive cycles with matching data and addresses, and `fetch_cnt`=9.
- Fetch address 0x6 → `rsp_fault`=2'b01, `rsp_instr`=0x0000_0013. Fetch address 4·DEPTH → `rsp_fault`=2'b10. Fetch 4·DEPTH+2 → `rsp_fault`=2'b11.
- Hold `rsp_ready`=0 for 5 cycles with `req_valid`=1. Required: outputs stable, `req_ready`=0, and the next request is accepted only in the cycle `rsp_ready` rises.
- Assert `flush` while `rsp_valid`=1 and `rsp_ready`=0. Required: `rsp_valid`=0 next cycle, `fetch_cnt` unchanged, and no accept in the flush cycle.
- Assert `ld_en` with `req_valid`=1 → `req_ready`=0. Write 0xDEAD_BEEF to index 3, then fetch 12 the next cycle → 0xDEAD_BEEF.
- Drop `rst_n` while a response is held. Required: `rsp_valid` falls immediately and the counter reads 0. After release, a fetch still returns the loaded data.
